// File: rtl/swt_debounce.sv
// swt_debounce: two-flop synchroniser plus per-bit stability counter for slide switches; optional CHG strobe under SWT_DEBOUNCE_CHG_EN.
// Latency: SWT_OUT follows a held input DEBOUNCE_CYCLES+1 edges after the first edge that samples it.
// Backpressure: none; free-running, every bit is evaluated on every clock.
module swt_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] SWT_IN,
   output logic [WIDTH-1:0] SWT_OUT,
   output logic             BUSY,
   output logic [WIDTH-1:0] CHG
);

   localparam logic [CNT_W-1:0] cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] upd;
   logic [WIDTH-1:0] pend;
   logic [CNT_W-1:0] cnt [WIDTH];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= SWT_IN;
         s2 <= s1;
      end
   end

   // A bit commits once its counter has seen DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      upd  = '0;
      pend = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upd[i]  = (s2[i] != SWT_OUT[i]) && (cnt[i] == cnt_max);
         pend[i] = (cnt[i] != '0);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         SWT_OUT <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == SWT_OUT[i] || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (upd[i]) begin
               SWT_OUT[i] <= s2[i];
            end
         end
      end
   end

   assign BUSY = |pend;

`ifdef SWT_DEBOUNCE_CHG_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CHG <= '0;
      end else begin
         CHG <= upd;
      end
   end
`else
   assign CHG = '0;
`endif

endmodule

// File: tb/tb_swt_debounce.sv
// Bench for swt_debounce with DEBOUNCE_CYCLES=4: sample-history model checked every cycle plus directed literal checks.
module tb_swt_debounce;

   localparam int W  = 4;
   localparam int DB = 4;

   logic         CLK;
   logic         RST;
   logic [W-1:0] SWT_IN;
   logic [W-1:0] SWT_OUT;
   logic         BUSY;
   logic [W-1:0] CHG;

   int checks = 0;
   int errors = 0;

   swt_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .CLK(CLK), .RST(RST), .SWT_IN(SWT_IN),
      .SWT_OUT(SWT_OUT), .BUSY(BUSY), .CHG(CHG)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: hist[k] is the input sampled k+1 edges ago. A bit flips when the
   // last DB synchronised values (sampled 2..DB+1 edges ago) all differ from it.
   logic [W-1:0] hist [0:DB];
   logic [W-1:0] m_out;
   logic [W-1:0] m_chg;
   logic [W-1:0] m_flip;
   logic         m_busy;
   logic [W-1:0] exp_chg;

   always_comb begin
      m_flip = '1;
      for (int k = 1; k <= DB; k++) begin
         m_flip = m_flip & (hist[k] ^ m_out);
      end
   end

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k <= DB; k++) hist[k] <= '0;
         m_out <= '0;
         m_chg <= '0;
      end else begin
         hist[0] <= SWT_IN;
         for (int k = 1; k <= DB; k++) hist[k] <= hist[k-1];
         m_out <= m_out ^ m_flip;
         m_chg <= m_flip;
      end
   end

   assign m_busy = |(hist[2] ^ m_out);
`ifdef SWT_DEBOUNCE_CHG_EN
   assign exp_chg = m_chg;
`else
   assign exp_chg = '0;
`endif

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      check("model_out", SWT_OUT, m_out);
      check("model_busy", {3'b000, BUSY}, {3'b000, m_busy});
      check("model_chg", CHG, exp_chg);
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CLK);
   endtask

   logic [W-1:0] chg_step;
   logic [W-1:0] prev;
   logic [W-1:0] vv;
   logic         aoi_dut;
   logic         aoi_exp;
   assign aoi_dut = ~((SWT_OUT[0] & SWT_OUT[1]) | (SWT_OUT[2] & SWT_OUT[3]));

   initial begin
`ifdef SWT_DEBOUNCE_CHG_EN
      chg_step = 4'b0101;
`else
      chg_step = 4'b0000;
`endif
      RST = 1'b1;
      SWT_IN = 4'b1111;
      wait_neg(3);
      check("rst_out", SWT_OUT, 4'b0000);
      check("rst_busy", {3'b000, BUSY}, 4'b0000);
      check("rst_chg", CHG, 4'b0000);
      RST = 1'b0;
      wait_neg(5);
      check("rel_e4", SWT_OUT, 4'b0000);
      wait_neg(1);
      check("rel_e5", SWT_OUT, 4'b1111);

      // clean step
      SWT_IN = 4'b0000;
      wait_neg(8);
      SWT_IN = 4'b0101;
      wait_neg(2);
      check("step_busy_e1", {3'b000, BUSY}, 4'b0000);
      wait_neg(1);
      check("step_busy_e2", {3'b000, BUSY}, 4'b0001);
      wait_neg(2);
      check("step_busy_e4", {3'b000, BUSY}, 4'b0001);
      check("step_out_e4", SWT_OUT, 4'b0000);
      wait_neg(1);
      check("step_out_e5", SWT_OUT, 4'b0101);
      check("step_busy_e5", {3'b000, BUSY}, 4'b0000);
      check("step_chg_e5", CHG, chg_step);
      wait_neg(1);
      check("step_chg_e6", CHG, 4'b0000);

      // glitch reject
      SWT_IN = 4'b0000;
      wait_neg(8);
      SWT_IN = 4'b0001;
      wait_neg(3);
      SWT_IN = 4'b0000;
      wait_neg(1);
      check("glitch_busy_e3", {3'b000, BUSY}, 4'b0001);
      wait_neg(2);
      check("glitch_busy_e5", {3'b000, BUSY}, 4'b0000);
      check("glitch_out_e5", SWT_OUT, 4'b0000);
      wait_neg(4);
      check("glitch_out_late", SWT_OUT, 4'b0000);
      check("glitch_chg", CHG, 4'b0000);

      // independent bits
      SWT_IN = 4'b1000;
      wait_neg(2);
      SWT_IN = 4'b1010;
      wait_neg(3);
      check("indep_e4", SWT_OUT, 4'b0000);
      wait_neg(1);
      check("indep_e5", SWT_OUT, 4'b1000);
      wait_neg(1);
      check("indep_e6", SWT_OUT, 4'b1000);
      wait_neg(1);
      check("indep_e7", SWT_OUT, 4'b1010);

      // reset mid-count
      SWT_IN = 4'b0000;
      wait_neg(10);
      SWT_IN = 4'b1000;
      wait_neg(3);
      check("mid_busy", {3'b000, BUSY}, 4'b0001);
      RST = 1'b1;
      #1;
      check("mid_rst_out", SWT_OUT, 4'b0000);
      check("mid_rst_busy", {3'b000, BUSY}, 4'b0000);
      wait_neg(2);
      RST = 1'b0;
      wait_neg(5);
      check("mid_e4", SWT_OUT, 4'b0000);
      wait_neg(1);
      check("mid_e5", SWT_OUT, 4'b1000);

      // exhaustive sweep with downstream AOI
      SWT_IN = 4'b0000;
      wait_neg(8);
      prev = 4'b0000;
      for (int v = 0; v < 16; v++) begin
         vv = v[W-1:0];
         SWT_IN = vv;
         wait_neg(5);
         check("sweep_hold", SWT_OUT, prev);
         wait_neg(1);
         check("sweep_out", SWT_OUT, vv);
         aoi_exp = ~((vv[0] & vv[1]) | (vv[2] & vv[3]));
         check("sweep_aoi", {3'b000, aoi_dut}, {3'b000, aoi_exp});
         wait_neg(2);
         prev = vv;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/swt_debounce.md
# swt_debounce

Synchronises and debounces the raw Basys3 slide switches before they reach the combinational logic stages (the AOI gate and its seven-segment output). Each switch bit gets a two-flop synchroniser and its own stability counter. The filtered bit updates only after the synchronised input has held a new level for DEBOUNCE_CYCLES consecutive clocks. Its output SWT_OUT connects directly to the downstream SWT[3:0] input.

## Interface
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 1000000: required stable clocks (10 ms at 100 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 20: width of each per-bit counter.

- CLK  input  1  system clock, 100 MHz on board, all state on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- SWT_IN  input  WIDTH  raw, unsynchronised switch levels.
- SWT_OUT  output  WIDTH  debounced switch levels; bit i feeds downstream SWT[i].
- BUSY  output  1  high while any bit's counter is non-zero, meaning a change is pending.
- CHG  output  WIDTH  one-cycle change strobe per bit; present only when the feature below is enabled.

## Operation
- Synchroniser: s1 <= SWT_IN, s2 <= s1, per bit. Both stages reset to 0.
- Per bit i, on each rising edge:
  - s2[i] == SWT_OUT[i]: cnt[i] <= 0.
  - s2[i] != SWT_OUT[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != SWT_OUT[i] and cnt[i] == DEBOUNCE_CYCLES-1: SWT_OUT[i] <= s2[i], cnt[i] <= 0.
- Bits are fully independent. Simultaneous changes on several bits each run their own count; equal-timed changes update on the same edge.
- A glitch shorter than DEBOUNCE_CYCLES returns s2 to SWT_OUT and clears the counter. SWT_OUT does not move.
- The counter never wraps: it clears on update or on a match. The maximum value held is DEBOUNCE_CYCLES-1.
- BUSY = OR over i of (cnt[i] != 0). It is combinational from registers.
- DEBOUNCE_CYCLES = 1 degenerates to a pure synchroniser with one extra register stage.

## Timing
- Reset: s1, s2, cnt, SWT_OUT, CHG all 0 immediately (asynchronous). BUSY = 0.
- After RST deasserts, a switch that is already high produces SWT_OUT high at edge DEBOUNCE_CYCLES+1 after the first sampling edge. Nothing is preloaded.
- Latency: if SWT_IN[i] changes and holds, let edge 0 be the first edge that samples the new level. SWT_OUT[i] then changes on edge DEBOUNCE_CYCLES+1.
- Reset mid-count: the count is discarded. Debouncing restarts from zero after release.
- Minimum input pulse that propagates: DEBOUNCE_CYCLES+1 clocks measured at SWT_IN (synchroniser skew ±1 edge).

## Configuration
- Macro SWT_DEBOUNCE_CHG_EN.
- Defined: CHG[i] is registered high for exactly the one cycle following the edge where SWT_OUT[i] updates. It is high in the same cycle as the new SWT_OUT value, for both rising and falling changes.
- Undefined: the CHG port still exists and is tied to 0; no strobe logic is generated.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, CNT_W=3, WIDTH=4.
- Reset check: RST=1 with SWT_IN=4'b1111 -> SWT_OUT=0, BUSY=0, CHG=0 throughout reset. After release -> SWT_OUT=4'b1111 at edge 5 after the first sampling edge.
- Clean step: SWT_IN 0000 -> 0101 held -> SWT_OUT=0101 exactly at edge 5. BUSY is high on edges 2..4 and low after edge 5. With the macro, CHG=0101 for one cycle.
- Glitch reject: SWT_IN[0] high for 3 clocks, then low -> SWT_OUT stays 0000. BUSY pulses, then returns to 0. CHG stays 0.
- Independent bits: SWT_IN[3] rises at edge 0, SWT_IN[1] rises at edge 2 -> SWT_OUT[3] at edge 5, SWT_OUT[1] at edge 7.
- Reset mid-count: step SWT_IN to 1000, assert RST after 3 clocks, release -> SWT_OUT=0 during reset, then 1000 at edge 5 after the first post-release sampling edge.
- Exhaustive sweep: all 16 SWT_IN values, each held 8 clocks -> SWT_OUT equals each value 5 edges after it is applied. The downstream AOI output ~((a&b)|(c&d)) is checked against SWT_OUT.
